// File: rtl/pipelined_cla_adder.sv
// Three-stage carry-lookahead add/sub (group lookahead, then intra-group carries), 3-edge latency, 1 op/cycle.
// out_ready stalls propagate combinationally back to in_ready with no skid buffer; `define CLA_SATURATE_EN clamps overflowed sums.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NG = WIDTH / BLOCK;

  logic             adv1, adv2, adv3;
  logic             v1, v2;
  logic [WIDTH-1:0] b_eff;
  logic             c0_in;

  logic [WIDTH-1:0] p1, g1;
  logic             c01;

  logic [NG-1:0]    gp, gg;
  logic [NG:0]      gc;
  logic             la_c, la_acc, la_term;

  logic [WIDTH-1:0] p2, g2;
  logic [NG:0]      gc2;

  logic [WIDTH-1:0] cb, res;
  logic             la3_c, ovf;

`ifdef CLA_SATURATE_EN
  logic neg1, neg2;
`endif

  assign adv3     = !out_valid || out_ready;
  assign adv2     = !v2 || adv3;
  assign adv1     = !v1 || adv2;
  assign in_ready = adv1;

  assign b_eff = sub ? ~b : b;
  assign c0_in = sub ? ~cin : cin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1  <= 1'b0;
      p1  <= '0;
      g1  <= '0;
      c01 <= 1'b0;
    end else if (adv1) begin
      v1  <= in_valid;
      p1  <= a ^ b_eff;
      g1  <= a & b_eff;
      c01 <= c0_in;
    end
  end

  // Group P/G, then every group carry expanded directly from c0 (no ripple across groups).
  always_comb begin
    gp      = '0;
    gg      = '0;
    gc      = '0;
    la_c    = 1'b0;
    la_acc  = 1'b0;
    la_term = 1'b0;
    for (int k = 0; k < NG; k++) begin
      gp[k] = &p1[k*BLOCK +: BLOCK];
      la_c  = 1'b0;
      for (int i = 0; i < BLOCK; i++)
        la_c = g1[k*BLOCK+i] | (p1[k*BLOCK+i] & la_c);
      gg[k] = la_c;
    end
    gc[0] = c01;
    for (int k = 0; k < NG; k++) begin
      la_acc = c01;
      for (int m = 0; m <= k; m++)
        la_acc = la_acc & gp[m];
      for (int j = 0; j <= k; j++) begin
        la_term = gg[j];
        for (int m = j + 1; m <= k; m++)
          la_term = la_term & gp[m];
        la_acc = la_acc | la_term;
      end
      gc[k+1] = la_acc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2  <= 1'b0;
      p2  <= '0;
      g2  <= '0;
      gc2 <= '0;
    end else if (adv2) begin
      v2  <= v1;
      p2  <= p1;
      g2  <= g1;
      gc2 <= gc;
    end
  end

  always_comb begin
    cb    = '0;
    la3_c = 1'b0;
    for (int k = 0; k < NG; k++) begin
      la3_c = gc2[k];
      for (int i = 0; i < BLOCK; i++) begin
        cb[k*BLOCK+i] = la3_c;
        la3_c = g2[k*BLOCK+i] | (p2[k*BLOCK+i] & la3_c);
      end
    end
    ovf = gc2[NG] ^ cb[WIDTH-1];
    res = p2 ^ cb;
`ifdef CLA_SATURATE_EN
    // Overflow implies equal effective signs, so one sign flag picks the clamp direction.
    if (ovf)
      res = neg2 ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

`ifdef CLA_SATURATE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      neg1 <= 1'b0;
      neg2 <= 1'b0;
    end else begin
      if (adv1) neg1 <= a[WIDTH-1] & b_eff[WIDTH-1];
      if (adv2) neg2 <= neg1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (adv3) begin
      out_valid <= v2;
      sum       <= res;
      cout      <= gc2[NG];
      overflow  <= ovf;
      zero      <= (res == '0);
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed and random bench for pipelined_cla_adder against an arithmetic reference model.
module tb_pipelined_cla_adder;

  localparam int W  = 16;
  localparam int BL = 4;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, overflow, zero;

  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  int   n_del  = 0;
  logic last_acc;
  res_t q[$];
  res_t dq[$];

  pipelined_cla_adder #(.WIDTH(W), .BLOCK(BL)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed views of the operands.
  function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tc, input logic ts);
    longint ua, ub, sa, sb, ur, sr, smax, smin;
    res_t   r;
    ua   = longint'(ta);
    ub   = longint'(tb_);
    sa   = longint'($signed(ta));
    sb   = longint'($signed(tb_));
    smax = (longint'(1) << (W-1)) - 1;
    smin = -(longint'(1) << (W-1));
    if (!ts) begin
      ur  = ua + ub + longint'(tc);
      sr  = sa + sb + longint'(tc);
      r.c = ((ur >> W) & 1) != 0;
    end else begin
      ur  = ua - ub - longint'(tc);
      sr  = sa - sb - longint'(tc);
      r.c = (ur >= 0);
    end
    r.s = W'(ur);
    r.o = (sr > smax) || (sr < smin);
`ifdef CLA_SATURATE_EN
    if (sr > smax) r.s = W'(smax);
    else if (sr < smin) r.s = W'(smin);
`endif
    r.z = (r.s == '0);
    return r;
  endfunction

  task automatic step(input logic iv, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                      input logic tc, input logic ts, input logic ordy);
    res_t e;
    in_valid  = iv;
    a         = ta;
    b         = tb_;
    cin       = tc;
    sub       = ts;
    out_ready = ordy;
    last_acc  = 1'b0;
    @(negedge clk);
    if (in_valid && in_ready) begin
      q.push_back(model(ta, tb_, tc, ts));
      n_acc++;
      last_acc = 1'b1;
    end
    if (out_valid && out_ready) begin
      chk("dly_expected", q.size() != 0, 1);
      dq.push_back({sum, cout, overflow, zero});
      n_del++;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("dly_sum", sum, e.s);
        chk("dly_cout", cout, e.c);
        chk("dly_ovf", overflow, e.o);
        chk("dly_zero", zero, e.z);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic res_t dget(input int i);
    return (dq.size() > i) ? dq[i] : 'x;
  endfunction

  initial begin
    int   d0, acc0, idx;
    res_t r;
    logic [W-1:0] held_s;
    logic [2:0]   held_f;
    logic [W-1:0] bp_a[6];
    logic [W-1:0] bp_b[6];
    logic         bp_s[6];

    reset = 1'b0; in_valid = 1'b1; a = 16'h1234; b = 16'h4321;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ovld", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_zero", zero, 0);
    reset = 1'b1; in_valid = 1'b0;
    #1;
    chk("rst_irdy", in_ready, 1);

    // add wrap + 3-edge latency
    dq.delete();
    step(1, 16'hFFFF, 16'h0001, 0, 0, 1);
    chk("lat_e1", out_valid, 0);
    step(0, '0, '0, 0, 0, 1);
    chk("lat_e2", out_valid, 0);
    step(0, '0, '0, 0, 0, 1);
    chk("lat_e3", out_valid, 1);
    step(0, '0, '0, 0, 0, 1);
    chk("wrap_n", dq.size(), 1);
    r = dget(0);
    chk("wrap_sum", r.s, 16'h0000);
    chk("wrap_cout", r.c, 1);
    chk("wrap_zero", r.z, 1);
    chk("wrap_ovf", r.o, 0);

    // signed subtract overflow
    dq.delete();
    step(1, 16'h7FFF, 16'hFFFF, 0, 1, 1);
    repeat (3) step(0, '0, '0, 0, 0, 1);
    r = dget(0);
`ifdef CLA_SATURATE_EN
    chk("sovf_sum", r.s, 16'h7FFF);
`else
    chk("sovf_sum", r.s, 16'h8000);
`endif
    chk("sovf_cout", r.c, 0);
    chk("sovf_ovf", r.o, 1);

    // four back-to-back ops
    dq.delete();
    d0 = n_del;
    step(1, 16'd1, 16'd2, 0, 0, 1);
    step(1, 16'd100, 16'd200, 0, 0, 1);
    step(1, 16'h8000, 16'd1, 0, 1, 1);
    step(1, 16'd5, 16'd5, 0, 1, 1);
    step(0, '0, '0, 0, 0, 1);
    chk("strm_cnt5", n_del - d0, 2);
    step(0, '0, '0, 0, 0, 1);
    chk("strm_cnt6", n_del - d0, 3);
    step(0, '0, '0, 0, 0, 1);
    chk("strm_cnt7", n_del - d0, 4);
    chk("strm_r0", dget(0).s, 16'd3);
    chk("strm_r1", dget(1).s, 16'd300);
`ifdef CLA_SATURATE_EN
    chk("strm_r2", dget(2).s, 16'h8000);
`else
    chk("strm_r2", dget(2).s, 16'h7FFF);
`endif
    chk("strm_r2ovf", dget(2).o, 1);
    chk("strm_r3", dget(3).s, 16'd0);
    chk("strm_r3z", dget(3).z, 1);
    chk("strm_r3c", dget(3).c, 1);

    // backpressure: 6 ops, out_ready low for 5 cycles
    for (int i = 0; i < 6; i++) begin
      bp_a[i] = W'($urandom);
      bp_b[i] = W'($urandom);
      bp_s[i] = 1'($urandom);
    end
    idx = 0; acc0 = n_acc; held_s = '0; held_f = '0;
    for (int i = 0; i < 5; i++) begin
      step(1, bp_a[idx], bp_b[idx], 0, bp_s[idx], 0);
      if (last_acc) idx++;
      if (i == 2) begin
        chk("bp_ovld", out_valid, 1);
        held_s = sum;
        held_f = {cout, overflow, zero};
      end
      if (i > 2) begin
        chk("bp_hold_sum", sum, held_s);
        chk("bp_hold_flags", {cout, overflow, zero}, held_f);
      end
    end
    chk("bp_acc", n_acc - acc0, 3);
    chk("bp_irdy", in_ready, 0);
    d0 = n_del;
    for (int t = 0; t < 40 && (n_del - d0) < 6; t++) begin
      step(idx < 6, bp_a[idx % 6], bp_b[idx % 6], 0, bp_s[idx % 6], 1);
      if (last_acc) idx++;
    end
    chk("bp_del", n_del - d0, 6);
    chk("bp_qempty", q.size(), 0);

    // reset with ops in flight
    step(1, 16'd11, 16'd22, 0, 0, 1);
    step(1, 16'd33, 16'd44, 1, 0, 1);
    step(1, 16'd55, 16'd66, 0, 1, 1);
    chk("mr_ovld_pre", out_valid, 1);
    reset = 1'b0;
    #1;
    chk("mr_ovld", out_valid, 0);
    chk("mr_sum", sum, 0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    d0 = n_del;
    repeat (5) step(0, '0, '0, 0, 0, 1);
    chk("mr_stale", n_del - d0, 0);

    // random streaming with random stalls
    acc0 = n_acc;
    for (int t = 0; t < 30000 && (n_acc - acc0) < 10000; t++)
      step($urandom_range(0, 4) != 0, W'($urandom), W'($urandom), 1'($urandom),
           1'($urandom), $urandom_range(0, 4) != 0);
    for (int t = 0; t < 20 && q.size() > 0; t++)
      step(0, '0, '0, 0, 0, 1);
    chk("rnd_acc", n_acc - acc0, 10000);
    chk("rnd_qempty", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
